// File: rtl/hmc_rsp_flit_serializer.sv
`default_nettype none
// ============================================================================
// Module  : hmc_rsp_flit_serializer
// Brief   : Buffers HMC response packets and serializes them into FPW-flit words.
// Revision: 1.0  initial release
// ============================================================================
module hmc_rsp_flit_serializer #(
  parameter int FPW            = 4,
  parameter int FLIT_SIZE      = 128,
  parameter int DWIDTH         = FPW*FLIT_SIZE,
  parameter int MAX_LNG        = 9,
  parameter int PKT_FIFO_DEPTH = 2,
  parameter int PACK           = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pkt_valid,
  output logic                              pkt_ready,
  input  logic [MAX_LNG*FLIT_SIZE-1:0]      pkt_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DWIDTH-1:0]                 out_data,
  output logic [FPW-1:0]                    out_flit_valid,
  output logic [FPW-1:0]                    out_hdr,
  output logic [FPW-1:0]                    out_tail,
  output logic                              err_lng,
  output logic [$clog2(PKT_FIFO_DEPTH):0]   fifo_level
);

  localparam int c_PTR_W = $clog2(PKT_FIFO_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam int c_LW    = $clog2(MAX_LNG + 1);
  localparam int c_IW    = $clog2(MAX_LNG + FPW + 1);

  logic [MAX_LNG*FLIT_SIZE-1:0] r_mem [PKT_FIFO_DEPTH];
  logic [c_LW-1:0]              r_len [PKT_FIFO_DEPTH];
  logic [c_PTR_W-1:0]           r_wr_ptr, r_rd_ptr;
  logic [c_LVL_W-1:0]           r_level;
  logic [c_IW-1:0]              r_off;
  logic                         r_ready, r_err;
  logic                         r_out_valid;
  logic [DWIDTH-1:0]            r_out_data;
  logic [FPW-1:0]               r_out_fv, r_out_hdr, r_out_tail;

  logic [3:0]         w_lng;
  logic               w_lng_bad, w_push, w_load;
  logic [c_LW-1:0]    w_len_in;
  logic [c_PTR_W-1:0] w_rd_ptr2;
  logic [c_IW-1:0]    w_len0, w_len1, w_rem0, w_n0, w_n1, w_room, w_off_nxt, w_idx;
  logic               w_head_done, w_use2, w_second_done;
  logic [c_LVL_W-1:0] w_pop_cnt, w_level_nxt;
  logic [DWIDTH-1:0]  w_data;
  logic [FPW-1:0]     w_fv, w_hdr, w_tail;

  function automatic logic [FLIT_SIZE-1:0] sel_flit(
    input logic [MAX_LNG*FLIT_SIZE-1:0] pkt,
    input logic [c_IW-1:0]              idx
  );
    sel_flit = '0;
    for (int i = 0; i < MAX_LNG; i++)
      if (c_IW'(i) == idx) sel_flit = pkt[i*FLIT_SIZE +: FLIT_SIZE];
  endfunction

  assign w_lng     = pkt_data[10:7];
  assign w_lng_bad = (w_lng == 4'd0) || (32'(w_lng) > 32'(MAX_LNG));
  assign w_len_in  = w_lng_bad ? c_LW'(1) : c_LW'(w_lng);
  assign w_push    = pkt_valid && r_ready;

  // Head packet supplies flits from r_off; a second entry may top up the word when packing.
  assign w_rd_ptr2     = r_rd_ptr + c_PTR_W'(1);
  assign w_len0        = c_IW'(r_len[r_rd_ptr]);
  assign w_len1        = c_IW'(r_len[w_rd_ptr2]);
  assign w_rem0        = w_len0 - r_off;
  assign w_head_done   = (w_rem0 <= c_IW'(FPW));
  assign w_n0          = w_head_done ? w_rem0 : c_IW'(FPW);
  assign w_room        = c_IW'(FPW) - w_n0;
  assign w_use2        = (PACK != 0) && w_head_done && (r_level >= c_LVL_W'(2)) && (w_room != '0);
  assign w_second_done = w_use2 && (w_len1 <= w_room);
  assign w_n1          = !w_use2 ? '0 : (w_second_done ? w_len1 : w_room);

  assign w_load      = (!r_out_valid || out_ready) && (r_level != '0);
  assign w_pop_cnt   = !(w_load && w_head_done) ? '0 :
                       (w_second_done ? c_LVL_W'(2) : c_LVL_W'(1));
  assign w_off_nxt   = !w_head_done ? (r_off + w_n0) :
                       ((w_use2 && !w_second_done) ? w_n1 : '0);
  assign w_level_nxt = r_level + c_LVL_W'(w_push) - w_pop_cnt;

  always_comb begin
    w_data = '0;
    w_fv   = '0;
    w_hdr  = '0;
    w_tail = '0;
    w_idx  = '0;
    for (int k = 0; k < FPW; k++) begin
      if (c_IW'(k) < w_n0) begin
        w_idx = r_off + c_IW'(k);
        w_data[k*FLIT_SIZE +: FLIT_SIZE] = sel_flit(r_mem[r_rd_ptr], w_idx);
        w_fv[k]   = 1'b1;
        w_hdr[k]  = (w_idx == '0);
        w_tail[k] = (w_idx == w_len0 - c_IW'(1));
      end else if (c_IW'(k) < w_n0 + w_n1) begin
        w_idx = c_IW'(k) - w_n0;
        w_data[k*FLIT_SIZE +: FLIT_SIZE] = sel_flit(r_mem[w_rd_ptr2], w_idx);
        w_fv[k]   = 1'b1;
        w_hdr[k]  = (w_idx == '0);
        w_tail[k] = (w_idx == w_len1 - c_IW'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= pkt_data;
      r_len[r_wr_ptr] <= w_len_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_off       <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_fv    <= '0;
      r_out_hdr   <= '0;
      r_out_tail  <= '0;
    end else begin
      r_err   <= w_push && w_lng_bad;
      r_ready <= (w_level_nxt < c_LVL_W'(PKT_FIFO_DEPTH));
      r_level <= w_level_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop_cnt);
      if (w_load) begin
        r_off       <= w_off_nxt;
        r_out_valid <= 1'b1;
        r_out_data  <= w_data;
        r_out_fv    <= w_fv;
        r_out_hdr   <= w_hdr;
        r_out_tail  <= w_tail;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_fv    <= '0;
        r_out_hdr   <= '0;
        r_out_tail  <= '0;
      end
    end
  end

  assign pkt_ready      = r_ready;
  assign err_lng        = r_err;
  assign fifo_level     = r_level;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_flit_valid = r_out_fv;
  assign out_hdr        = r_out_hdr;
  assign out_tail       = r_out_tail;

endmodule
`default_nettype wire

// File: doc/hmc_rsp_flit_serializer.md
# hmc_rsp_flit_serializer

Parametrised RTL serializer in the HMC response path. It accepts whole response packets of 1..MAX_LNG flits and emits FPW-flit-wide words on the PHY-side RX data bus toward the link controller. Per-lane flit-valid, header and tail flags are registered alongside the data. It supports an optional packing mode that lets two packets share one word, and buffers packets in a parametrised FIFO with valid/ready flow control on both sides.

## Interface
- FPW, 4: flits per word; legal values 2, 4, 6, 8.
- FLIT_SIZE, 128: bits per flit.
- DWIDTH, FPW*FLIT_SIZE: output word width (derived).
- MAX_LNG, 9: maximum packet length in flits.
- PKT_FIFO_DEPTH, 2: packet FIFO entries; must be a power of two, ≥2.
- PACK, 0: 0 = each packet starts at lane 0; 1 = the next packet continues in the free lanes of the current word.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- pkt_valid  in  1  input packet valid.
- pkt_ready  out  1  FIFO can accept a packet.
- pkt_data  in  MAX_LNG*FLIT_SIZE  packet; flit 0 in bits [FLIT_SIZE-1:0]; LNG is taken from flit 0 bits [10:7].
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DWIDTH  lane k = bits [k*FLIT_SIZE +: FLIT_SIZE].
- out_flit_valid  out  FPW  lane holds a flit.
- out_hdr  out  FPW  lane holds a header flit.
- out_tail  out  FPW  lane holds a tail flit.
- err_lng  out  1  one-cycle pulse on acceptance of a packet with illegal LNG.
- fifo_level  out  $clog2(PKT_FIFO_DEPTH)+1  number of stored packets.

## Operation
- **Accept.** A packet is accepted when pkt_valid && pkt_ready and is written into the FIFO together with its effective length.
  - pkt_ready = (fifo_level < PKT_FIFO_DEPTH).
  - No same-cycle pop/push bypass when full.
- **Illegal LNG.** LNG = 0 or LNG > MAX_LNG: effective length is 1, err_lng pulses in the cycle after acceptance, and the packet is still emitted.
- **Read pointer.** The head packet carries a flit offset `off` (0..MAX_LNG-1).
- **Output load.** The output register loads when (!out_valid || out_ready) and at least one flit is available. Otherwise, on out_ready it clears out_valid and all flag vectors.
- **Word fill.** Lanes are filled in ascending order:
  - Head flits run from `off` up to the head's length; `off` advances by the number of flits taken.
  - When the head packet completes, it is popped and `off` returns to 0.
  - PACK=1: remaining lanes take flits from the next FIFO entry, if one is present in that cycle. At most 2 packets contribute to one word; if the second packet does not finish within the word, it becomes the head with `off` set accordingly.
  - PACK=0, or no second packet available: remaining lanes carry zero data with cleared flags. The block never waits to fill a word.
- **Flags.**
  - out_hdr set on the lane carrying flit 0 of a packet.
  - out_tail set on the lane carrying flit (len-1).
  - A 1-flit packet has both flags on the same lane.
- **Word count.** With PACK=0 a packet occupies exactly ceil(len/FPW) consecutive words.
- **Stability.** While out_valid && !out_ready, out_data and all flags are held stable.
- **Reset.** rst clears the FIFO, `off` and the output register. It discards any packet mid-transmission, with no partial tail word. A subsequent packet begins at lane 0.

## Timing
- **Reset values.** All outputs 0 during and after reset, except pkt_ready, which is 0 during reset and 1 from the first cycle after rst deasserts.
- **Latency.** Packet accepted at the cycle-N edge: its first word has out_valid = 1 in cycle N+2 if the output register is free. Subsequent words follow every cycle with out_ready held high.
- **Throughput.** One word per cycle. pkt_ready reacts to a pop one cycle later.
- **fifo_level.** Registered; updated on the same edge as push/pop. Simultaneous push and pop leaves it unchanged.
- **Two-packet pop.** A word that completes two packets pops both on that edge.
- **err_lng** is registered, one cycle wide per offending packet.

## Test plan
- **Single flit, PACK=0, FPW=4.** Packet LNG=1 accepted in cycle 0 -> cycle 2: out_valid=1, flit_valid=0001, hdr=0001, tail=0001, lanes 1-3 zero.
- **Maximum length, PACK=0, FPW=4.** LNG=9, out_ready=1 -> 3 consecutive words:
  - flit_valid 1111, 1111, 0001
  - hdr 0001 on word 1
  - tail 0001 on word 3
- **Packing, PACK=1, FPW=4.** Back-to-back packets A (LNG=3) and B (LNG=2):
  - word 1 = A0 A1 A2 B0, flit_valid=1111, hdr=1001, tail=0100
  - word 2 = B1, flit_valid=0001, tail=0001
- **Backpressure.** out_ready=0 for 6 cycles with continuous LNG=2 input, DEPTH=2:
  - out_data and flags constant
  - fifo_level reaches 2 and pkt_ready=0
  - raising out_ready drains all packets in order with no loss or duplication
- **Illegal LNG.** LNG=0, then LNG=12 -> two err_lng pulses; each packet emitted as one flit with hdr=tail=0001.
- **Reset mid-packet.** rst during word 2 of an LNG=9 packet -> all outputs 0 next cycle; fifo_level=0; the next LNG=1 packet emits at lane 0.
